// File: rtl/dcache_wb.sv
`default_nettype none
// ============================================================================
// dcache_wb : direct-mapped write-back / write-allocate data cache, line bus
// Rev 1.0
// ============================================================================
module dcache_wb #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int SET_ADDR_LEN  = 3,
  parameter int TAG_LEN       = 32 - 2 - LINE_ADDR_LEN - SET_ADDR_LEN
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 rd_req,
  input  logic                                 wr_req,
  input  logic [31:0]                          addr,
  input  logic [31:0]                          wr_data,
  output logic [31:0]                          rd_data,
  output logic                                 miss,
  output logic                                 mem_rd_req,
  output logic                                 mem_wr_req,
  output logic [31:0]                          mem_addr,
  output logic [32*(2**LINE_ADDR_LEN)-1:0]     mem_wr_line,
  input  logic [32*(2**LINE_ADDR_LEN)-1:0]     mem_rd_line,
  input  logic                                 mem_gnt,
  output logic [31:0]                          access_cnt,
  output logic [31:0]                          miss_cnt
);

  localparam int SETS      = 2**SET_ADDR_LEN;
  localparam int LINE_BITS = 32*(2**LINE_ADDR_LEN);

  localparam logic [1:0] c_IDLE       = 2'd0;
  localparam logic [1:0] c_SWAP_OUT   = 2'd1;
  localparam logic [1:0] c_SWAP_IN    = 2'd2;
  localparam logic [1:0] c_SWAP_IN_OK = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [SETS-1:0]       valid_q, dirty_q;
  logic [TAG_LEN-1:0]    tag_q  [SETS];
  logic [LINE_BITS-1:0]  data_q [SETS];
  logic [31:0]           access_cnt_q, miss_cnt_q;

  logic [LINE_ADDR_LEN-1:0] w_word_off;
  logic [SET_ADDR_LEN-1:0]  w_set;
  logic [TAG_LEN-1:0]       w_tag;
  logic [LINE_BITS-1:0]     w_cur_line;
  logic                     w_req, w_hit, w_miss_idle, w_refill;
  logic                     w_unused_addr;

  assign w_word_off    = addr[LINE_ADDR_LEN+1:2];
  assign w_set         = addr[LINE_ADDR_LEN+2 +: SET_ADDR_LEN];
  assign w_tag         = addr[31 -: TAG_LEN];
  assign w_unused_addr = ^addr[1:0];
  assign w_cur_line    = data_q[w_set];

  assign w_req       = rd_req | wr_req;
  assign w_hit       = w_req && valid_q[w_set] && (tag_q[w_set] == w_tag) && (state_q == c_IDLE);
  assign w_miss_idle = w_req && !w_hit && (state_q == c_IDLE);
  assign w_refill    = (state_q == c_SWAP_IN) && mem_gnt;

  // A simultaneous rd/wr is a write, so it never returns read data.
  assign rd_data    = (w_hit && !wr_req) ? w_cur_line[{w_word_off, 5'b0} +: 32] : 32'd0;
  assign miss       = (state_q != c_IDLE) || (w_req && !w_hit);
  assign mem_wr_req = (state_q == c_SWAP_OUT);
  assign mem_rd_req = (state_q == c_SWAP_IN);
  assign access_cnt = access_cnt_q;
  assign miss_cnt   = miss_cnt_q;

  always_comb begin
    mem_addr    = 32'd0;
    mem_wr_line = '0;
    if (state_q == c_SWAP_OUT) begin
      mem_addr    = {tag_q[w_set], w_set, {(LINE_ADDR_LEN+2){1'b0}}};
      mem_wr_line = w_cur_line;
    end else if (state_q == c_SWAP_IN) begin
      mem_addr    = {w_tag, w_set, {(LINE_ADDR_LEN+2){1'b0}}};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:       if (w_miss_idle)
                      state_d = (valid_q[w_set] && dirty_q[w_set]) ? c_SWAP_OUT : c_SWAP_IN;
      c_SWAP_OUT:   if (mem_gnt) state_d = c_SWAP_IN;
      c_SWAP_IN:    if (mem_gnt) state_d = c_SWAP_IN_OK;
      c_SWAP_IN_OK: state_d = c_IDLE;
      default:      state_d = c_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= c_IDLE;
      valid_q      <= '0;
      dirty_q      <= '0;
      access_cnt_q <= 32'd0;
      miss_cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      if (w_hit)       access_cnt_q <= access_cnt_q + 32'd1;
      if (w_miss_idle) miss_cnt_q   <= miss_cnt_q + 32'd1;
      if (w_hit && wr_req) dirty_q[w_set] <= 1'b1;
      if (w_refill) begin
        valid_q[w_set] <= 1'b1;
        dirty_q[w_set] <= 1'b0;
      end
    end
  end

  // Line storage and tags survive reset; only valid/dirty are cleared.
  always_ff @(posedge clk) begin
    if (w_refill) begin
      data_q[w_set] <= mem_rd_line;
      tag_q[w_set]  <= w_tag;
    end else if (w_hit && wr_req) begin
      data_q[w_set][{w_word_off, 5'b0} +: 32] <= wr_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dcache_wb.sv
`default_nettype none
// ============================================================================
// tb_dcache_wb : randomized bench for dcache_wb against a transparent-memory model
// Rev 1.0
// ============================================================================
module tb_dcache_wb;

  logic         clk = 1'b0, rst = 1'b1, rd_req = 1'b0, wr_req = 1'b0, mem_gnt = 1'b0;
  logic [31:0]  addr = 32'd0, wr_data = 32'd0;
  logic [31:0]  rd_data, mem_addr, access_cnt, miss_cnt;
  logic         miss, mem_rd_req, mem_wr_req;
  logic [255:0] mem_wr_line;
  logic [255:0] mem_rd_line = '0;

  dcache_wb dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .wr_req(wr_req), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .miss(miss), .mem_rd_req(mem_rd_req),
    .mem_wr_req(mem_wr_req), .mem_addr(mem_addr), .mem_wr_line(mem_wr_line),
    .mem_rd_line(mem_rd_line), .mem_gnt(mem_gnt), .access_cnt(access_cnt),
    .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  // Backing memory (responder side) and architectural view of memory.
  logic [31:0] mem    [1024];
  logic [31:0] shadow [1024];
  // Which line each set should hold, and whether it has unwritten data.
  bit          m_valid [8];
  bit          m_dirty [8];
  int unsigned m_tag   [8];
  int unsigned exp_acc = 0, exp_miss = 0;
  int          n_tests = 0, n_fail = 0;

  int cur_lat = 1;
  int lat_cnt = 0;
  bit stray_req = 1'b0;

  logic [31:0]  last_wb_addr, last_rd_addr;
  logic [255:0] last_wb_line;
  bit           last_wb_seen;
  int           last_cyc;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Fixed-latency line memory: grants on the cur_lat-th cycle of a request.
  initial forever begin
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    if (stray_req) begin
      stray_req   = 1'b0;
      mem_gnt     = 1'b1;
      mem_rd_line = {8{$urandom}};
      lat_cnt     = 0;
    end else if (!rst && (mem_rd_req || mem_wr_req)) begin
      lat_cnt++;
      if (lat_cnt >= cur_lat) begin
        lat_cnt = 0;
        mem_gnt = 1'b1;
        for (int w = 0; w < 8; w++) begin
          if (mem_wr_req) mem[int'(mem_addr[11:2]) + w] = mem_wr_line[32*w +: 32];
          else            mem_rd_line[32*w +: 32] = mem[int'(mem_addr[11:2]) + w];
        end
      end
    end else begin
      lat_cnt = 0;
    end
  end

  task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input int lat);
    int unsigned  s, t;
    int           cyc, rd_cycles, excl_bad, unstable;
    bit           hit, wb, rd_seen, wr_seen, order_bad;
    logic [31:0]  wb_addr, line_addr;
    logic [255:0] exp_line;
    s         = (a >> 5) & 32'd7;
    t         = a >> 8;
    hit       = m_valid[s] && (m_tag[s] == t);
    wb        = !hit && m_valid[s] && m_dirty[s];
    wb_addr   = (m_tag[s] << 8) | (s << 5);
    line_addr = a & 32'hFFFF_FFE0;
    for (int w = 0; w < 8; w++) exp_line[32*w +: 32] = shadow[int'(wb_addr >> 2) + w];
    cyc = 0; rd_cycles = 0; excl_bad = 0; unstable = 0;
    rd_seen = 0; wr_seen = 0; order_bad = 0;
    cur_lat = lat;
    @(posedge clk); #1;
    rd_req = rd; wr_req = wr; addr = a; wr_data = d;
    @(negedge clk);
    chk("miss_now", miss, !hit);
    while (miss && cyc < 400) begin
      cyc++;
      if (mem_rd_req && mem_wr_req) excl_bad++;
      if (mem_wr_req) begin
        if (rd_seen) order_bad = 1;
        if (!wr_seen) begin
          last_wb_addr = mem_addr;
          last_wb_line = mem_wr_line;
        end else if (mem_addr != last_wb_addr || mem_wr_line != last_wb_line) unstable++;
        wr_seen = 1;
      end
      if (mem_rd_req) begin
        if (!rd_seen) last_rd_addr = mem_addr;
        else if (mem_addr != last_rd_addr) unstable++;
        rd_seen = 1;
        rd_cycles++;
      end
      @(negedge clk);
    end
    chk("miss_cycles", cyc, hit ? 0 : (wb ? 2*lat + 2 : lat + 2));
    if (rd && !wr) chk("rd_data", rd_data, shadow[a >> 2]);
    else           chk("rd_data_on_write", rd_data, 0);
    chk("wb_seen", wr_seen, wb);
    chk("req_exclusive", excl_bad, 0);
    chk("req_stable", unstable, 0);
    chk("wb_before_refill", order_bad, 0);
    if (wb) begin
      chk("wb_addr", last_wb_addr, wb_addr);
      chk("wb_line", last_wb_line, exp_line);
    end
    if (!hit) begin
      chk("refill_addr", last_rd_addr, line_addr);
      chk("refill_cycles", rd_cycles, lat);
    end
    if (!hit) begin
      m_valid[s] = 1; m_tag[s] = t; m_dirty[s] = 0;
      exp_miss++;
    end
    exp_acc++;
    if (wr) begin
      m_dirty[s] = 1;
      shadow[a >> 2] = d;
    end
    @(posedge clk); #1;
    rd_req = 0; wr_req = 0;
    chk("access_cnt", access_cnt, exp_acc);
    chk("miss_cnt", miss_cnt, exp_miss);
    last_wb_seen = wr_seen;
    last_cyc     = cyc;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
    for (int i = 0; i < 1024; i++) shadow[i] = mem[i];
    exp_acc  = 0;
    exp_miss = 0;
  endtask

  initial begin
    logic [31:0] ra;
    int          op;
    bit          saw;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[16] = 32'hA5A5_0001;
    for (int i = 0; i < 8; i++) m_tag[i] = 0;
    model_reset();

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_miss", miss, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_wr_line", mem_wr_line, 0);
    chk("rst_mem_reqs", {mem_rd_req, mem_wr_req}, 0);
    chk("rst_counters", {access_cnt, miss_cnt}, 0);

    // Cold read miss, latency 5.
    access(1, 0, 32'h0000_0040, 0, 5);
    chk("cold_miss_len", last_cyc, 7);
    chk("cold_no_wb", last_wb_seen, 0);

    // Write hit, read hit.
    access(0, 1, 32'h0000_0044, 32'hDEAD_BEEF, 3);
    access(1, 0, 32'h0000_0044, 0, 3);

    // Dirty eviction of set 2, then the evicted line comes back clean.
    access(1, 0, 32'h0000_0140, 0, 4);
    chk("evict_wb_addr", last_wb_addr, 32'h0000_0040);
    chk("evict_word1", last_wb_line[63:32], 32'hDEAD_BEEF);
    access(1, 0, 32'h0000_0044, 0, 4);
    chk("reread_clean", last_wb_seen, 0);

    // Long grant wait, then a stray grant while idle.
    access(1, 0, 32'h0000_0240, 0, 20);
    @(negedge clk);
    stray_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("stray_miss", miss, 0);
    chk("stray_counters", {access_cnt, miss_cnt}, {exp_acc, exp_miss});
    access(1, 0, 32'h0000_0240, 0, 3);

    // Randomized traffic over 8 tags x 8 sets.
    repeat (150) begin
      ra = $urandom_range(0, 511) << 2;
      op = $urandom_range(0, 3);
      access(op != 1, (op == 1) || (op == 2), ra, $urandom, $urandom_range(1, 6));
    end

    // Reset in the middle of a write-back.
    access(0, 1, 32'h0000_0060, 32'hCAFE_F00D, 2);
    cur_lat = 10;
    @(posedge clk); #1;
    rd_req = 1; addr = 32'h0000_0160;
    saw = 0;
    for (int i = 0; i < 20 && !saw; i++) begin
      @(negedge clk);
      saw = mem_wr_req;
    end
    chk("rst_test_wb_started", saw, 1);
    rst = 1'b1; rd_req = 0;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_wr_req", mem_wr_req, 0);
    chk("midrst_miss", miss, 0);
    chk("midrst_counters", {access_cnt, miss_cnt}, 0);
    model_reset();
    access(1, 0, 32'h0000_0060, 0, 3);
    chk("midrst_discard", last_wb_seen, 0);

    // Simultaneous rd/wr on a hit behaves as a write.
    access(1, 0, 32'h0000_0048, 0, 3);
    access(1, 1, 32'h0000_0048, 32'h1234_5678, 3);
    access(1, 0, 32'h0000_0048, 0, 2);
    access(1, 0, 32'h0000_0148, 0, 3);
    chk("rw_dirty", last_wb_seen, 1);
    chk("rw_word2", last_wb_line[95:64], 32'h1234_5678);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
